frame_buf_ctrl: RTL and testbench

Controller that sequences the 30-frame x 8-pixel pixel frame buffer RAM as a frame-granular ring FIFO.
- Write side: a pixel stream is packed into consecutive frame slots.
- Read side: complete frames are replayed in order over a valid/ready stream, issuing single-cycle read pulses to the RAM and absorbing its 2-cycle read latency.
- Sits between the pixel capture front end and the downstream readout/serialiser.

---
 rtl/fb_pkg.sv | 23 ++
 rtl/frame_buf_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_frame_buf_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared constants, read-FSM state type and ring-pointer helper for the
// frame buffer controller.
package fb_pkg;

  localparam int unsigned NUM_FRAMES    = 30;
  localparam int unsigned PIX_PER_FRAME = 8;
  localparam int unsigned DATA_W        = 10;
  localparam int unsigned PADDR_W       = 4;
  localparam int unsigned FRAME_W       = 5;
  localparam int unsigned PIDX_W        = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } rd_state_e;

  function automatic logic [FRAME_W-1:0] ptr_wrap(input logic [FRAME_W-1:0] p);
    return (p == FRAME_W'(NUM_FRAMES - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/frame_buf_ctrl.sv
// Frame-granular ring FIFO sequencer for the pixel frame buffer RAM: packs the
// input pixel stream into frame slots and replays complete frames in order.
module frame_buf_ctrl
  import fb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  input  logic               s_sof,
  input  logic [DATA_W-1:0]  s_data,
  input  logic [PADDR_W-1:0] s_addr,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DATA_W-1:0]  m_data,
  output logic [PADDR_W-1:0] m_addr,
  output logic               m_last,
  output logic [FRAME_W-1:0] m_frame,
  output logic               ram_write_en,
  output logic [DATA_W-1:0]  ram_pixel_data_in,
  output logic [PADDR_W-1:0] ram_pixel_addr_in,
  output logic [FRAME_W-1:0] ram_frame_sel,
  output logic [PIDX_W-1:0]  ram_pixel_index_in,
  output logic               ram_read_en,
  output logic [FRAME_W-1:0] ram_frame_read_sel,
  output logic [PIDX_W-1:0]  ram_pixel_index_out,
  input  logic [DATA_W-1:0]  ram_pixel_data_out,
  input  logic [PADDR_W-1:0] ram_pixel_addr_out,
  input  logic               ram_valid_out,
  output logic [FRAME_W-1:0] frames_stored,
  output logic               overflow,
  output logic               sof_err
);

  localparam logic [PIDX_W-1:0]  LAST_IDX = PIDX_W'(PIX_PER_FRAME - 1);
  localparam logic [FRAME_W-1:0] FULL_CNT = FRAME_W'(NUM_FRAMES);

  logic [FRAME_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PIDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic               drop_q, drop_d;
  logic [FRAME_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PIDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [FRAME_W-1:0] count_q, count_d;
  rd_state_e          state_q, state_d;
  logic [DATA_W-1:0]  hold_data_q, hold_data_d;
  logic [PADDR_W-1:0] hold_addr_q, hold_addr_d;

  logic               m_valid_q, m_valid_d;
  logic               m_last_q, m_last_d;
  logic [FRAME_W-1:0] m_frame_q, m_frame_d;
  logic               ram_read_en_q, ram_read_en_d;
  logic [FRAME_W-1:0] ram_frame_read_sel_q, ram_frame_read_sel_d;
  logic [PIDX_W-1:0]  ram_pixel_index_out_q, ram_pixel_index_out_d;
  logic [FRAME_W-1:0] frames_stored_q, frames_stored_d;
  logic               overflow_q, overflow_d;
  logic               sof_err_q, sof_err_d;

  logic               wr_start;
  logic               full;
  logic [PIDX_W-1:0]  cur_idx;
  logic               cur_drop;
  logic               commit;
  logic               pop;

  // Write side: a mid-frame s_sof restarts the frame at index 0 in the same
  // slot, so the full check and drop decision are re-made for that pixel.
  always_comb begin
    wr_start = s_valid & ((wr_idx_q == '0) | s_sof);
    full     = (count_q == FULL_CNT);
    cur_idx  = wr_start ? '0 : wr_idx_q;
    cur_drop = wr_start ? full : drop_q;
    commit   = s_valid & ~cur_drop & (cur_idx == LAST_IDX);

    ram_write_en       = s_valid & ~cur_drop;
    ram_pixel_data_in  = s_data;
    ram_pixel_addr_in  = s_addr;
    ram_frame_sel      = wr_ptr_q;
    ram_pixel_index_in = cur_idx;

    wr_idx_d = wr_idx_q;
    drop_d   = drop_q;
    if (s_valid) begin
      wr_idx_d = (cur_idx == LAST_IDX) ? '0 : cur_idx + 1'b1;
      drop_d   = cur_drop;
    end
    wr_ptr_d   = commit ? ptr_wrap(wr_ptr_q) : wr_ptr_q;
    overflow_d = wr_start & full;
    sof_err_d  = s_valid & s_sof & (wr_idx_q != '0);
  end

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    rd_idx_d    = rd_idx_q;
    hold_data_d = hold_data_q;
    hold_addr_d = hold_addr_q;
    pop         = 1'b0;

    unique case (state_q)
      IDLE:  if (count_q != '0) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (ram_valid_out) begin
          hold_data_d = ram_pixel_data_out;
          hold_addr_d = ram_pixel_addr_out;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (m_ready) begin
          if (rd_idx_q == LAST_IDX) begin
            pop      = 1'b1;
            rd_idx_d = '0;
            rd_ptr_d = ptr_wrap(rd_ptr_q);
            state_d  = IDLE;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
            state_d  = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    count_d = count_q;
    if (commit && !pop) count_d = count_q + 1'b1;
    else if (pop && !commit) count_d = count_q - 1'b1;

    // Outputs are registered from the next-state view so they line up with state_q.
    ram_read_en_d         = (state_d == ISSUE);
    ram_frame_read_sel_d  = rd_ptr_d;
    ram_pixel_index_out_d = rd_idx_d;
    m_valid_d             = (state_d == HOLD);
    m_last_d              = (state_d == HOLD) && (rd_idx_d == LAST_IDX);
    m_frame_d             = rd_ptr_d;
    frames_stored_d       = count_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q              <= '0;
      wr_idx_q              <= '0;
      drop_q                <= 1'b0;
      rd_ptr_q              <= '0;
      rd_idx_q              <= '0;
      count_q               <= '0;
      state_q               <= IDLE;
      hold_data_q           <= '0;
      hold_addr_q           <= '0;
      m_valid_q             <= 1'b0;
      m_last_q              <= 1'b0;
      m_frame_q             <= '0;
      ram_read_en_q         <= 1'b0;
      ram_frame_read_sel_q  <= '0;
      ram_pixel_index_out_q <= '0;
      frames_stored_q       <= '0;
      overflow_q            <= 1'b0;
      sof_err_q             <= 1'b0;
    end else begin
      wr_ptr_q              <= wr_ptr_d;
      wr_idx_q              <= wr_idx_d;
      drop_q                <= drop_d;
      rd_ptr_q              <= rd_ptr_d;
      rd_idx_q              <= rd_idx_d;
      count_q               <= count_d;
      state_q               <= state_d;
      hold_data_q           <= hold_data_d;
      hold_addr_q           <= hold_addr_d;
      m_valid_q             <= m_valid_d;
      m_last_q              <= m_last_d;
      m_frame_q             <= m_frame_d;
      ram_read_en_q         <= ram_read_en_d;
      ram_frame_read_sel_q  <= ram_frame_read_sel_d;
      ram_pixel_index_out_q <= ram_pixel_index_out_d;
      frames_stored_q       <= frames_stored_d;
      overflow_q            <= overflow_d;
      sof_err_q             <= sof_err_d;
    end
  end

  assign m_valid             = m_valid_q;
  assign m_data              = hold_data_q;
  assign m_addr              = hold_addr_q;
  assign m_last              = m_last_q;
  assign m_frame             = m_frame_q;
  assign ram_read_en         = ram_read_en_q;
  assign ram_frame_read_sel  = ram_frame_read_sel_q;
  assign ram_pixel_index_out = ram_pixel_index_out_q;
  assign frames_stored       = frames_stored_q;
  assign overflow            = overflow_q;
  assign sof_err             = sof_err_q;

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Bench for frame_buf_ctrl: a 2-cycle-latency RAM model plus a frame-queue
// reference model checked every cycle under directed and random traffic.
module tb_frame_buf_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0, s_sof = 1'b0;
  logic [9:0] s_data = '0;
  logic [3:0] s_addr = '0;
  logic       m_valid, m_ready = 1'b0, m_last;
  logic [9:0] m_data;
  logic [3:0] m_addr;
  logic [4:0] m_frame;
  logic       ram_write_en, ram_read_en;
  logic [9:0] ram_pixel_data_in, ram_pixel_data_out;
  logic [3:0] ram_pixel_addr_in, ram_pixel_addr_out;
  logic [4:0] ram_frame_sel, ram_frame_read_sel, frames_stored;
  logic [2:0] ram_pixel_index_in, ram_pixel_index_out;
  logic       ram_valid_out = 1'b0;
  logic       overflow, sof_err;

  frame_buf_ctrl dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_sof(s_sof), .s_data(s_data), .s_addr(s_addr),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_addr(m_addr),
    .m_last(m_last), .m_frame(m_frame),
    .ram_write_en(ram_write_en), .ram_pixel_data_in(ram_pixel_data_in),
    .ram_pixel_addr_in(ram_pixel_addr_in), .ram_frame_sel(ram_frame_sel),
    .ram_pixel_index_in(ram_pixel_index_in), .ram_read_en(ram_read_en),
    .ram_frame_read_sel(ram_frame_read_sel), .ram_pixel_index_out(ram_pixel_index_out),
    .ram_pixel_data_out(ram_pixel_data_out), .ram_pixel_addr_out(ram_pixel_addr_out),
    .ram_valid_out(ram_valid_out), .frames_stored(frames_stored),
    .overflow(overflow), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  // RAM model: request sampled at edge t, data valid during cycle t+2.
  logic [13:0] mem [0:29][0:7];
  logic        p_en = 1'b0;
  logic [4:0]  p_f = '0;
  logic [2:0]  p_i = '0;
  always @(posedge clk) begin
    if (ram_write_en === 1'b1 && ram_frame_sel < 5'd30)
      mem[ram_frame_sel][ram_pixel_index_in] <= {ram_pixel_addr_in, ram_pixel_data_in};
    p_en <= (ram_read_en === 1'b1);
    p_f  <= ram_frame_read_sel;
    p_i  <= ram_pixel_index_out;
    ram_valid_out <= p_en;
    {ram_pixel_addr_out, ram_pixel_data_out} <= (p_f < 5'd30) ? mem[p_f][p_i] : '0;
  end

  typedef struct {
    logic [9:0] d;
    logic [3:0] a;
    logic [4:0] f;
    logic       last;
  } pix_t;

  // Reference model: committed pixels in replay order, plus the frame being written.
  pix_t        pq [$];
  pix_t        cur [0:7];
  int          mcount, wslot, pix;
  logic        mdrop;
  int          n_vec = 0, n_mis = 0;
  int          cyc = 0;
  int          rd_cycles [$];
  int          first_mv;
  logic        prev_mv, prev_rdy, prev_rd, prev_ml;
  logic [9:0]  prev_md;
  logic [3:0]  prev_ma;
  logic [4:0]  prev_mf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    pq.delete();
    mcount = 0; wslot = 0; pix = 0; mdrop = 1'b0;
    prev_mv = 1'b0; prev_rdy = 1'b0; prev_rd = 1'b0;
    rd_cycles.delete(); first_mv = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; m_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_frames_stored", frames_stored, 0);
    chk("rst_read_en", ram_read_en, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_sof_err", sof_err, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_frame", m_frame, 0);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic cyc_step(input logic v, input logic sof, input logic [9:0] d,
                          input logic [3:0] a, input logic rdy);
    logic        start, exp_ov, exp_se;
    int unsigned idx;
    pix_t        e;
    s_valid = v; s_sof = sof; s_data = d; s_addr = a; m_ready = rdy;
    @(negedge clk);
    cyc++;
    exp_ov = 1'b0; exp_se = 1'b0;
    idx = pix;
    start = v && (pix == 0 || sof);
    if (v && sof && pix != 0) exp_se = 1'b1;
    if (start) begin
      idx = 0;
      mdrop = (mcount == 30);
      exp_ov = mdrop;
    end
    chk("wr_en", ram_write_en, v && !mdrop);
    if (v && !mdrop) begin
      chk("wr_frame", ram_frame_sel, wslot);
      chk("wr_idx", ram_pixel_index_in, idx);
      chk("wr_data", ram_pixel_data_in, d);
      chk("wr_tag", ram_pixel_addr_in, a);
    end
    if (ram_read_en === 1'b1) begin
      chk("rd_pulse_single", prev_rd, 0);
      rd_cycles.push_back(cyc);
    end
    if (prev_mv && !prev_rdy) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_data", m_data, prev_md);
      chk("stall_tag", m_addr, prev_ma);
      chk("stall_last", m_last, prev_ml);
      chk("stall_frame", m_frame, prev_mf);
      chk("stall_no_read", ram_read_en, 0);
    end
    if (m_valid === 1'b1 && first_mv < 0) first_mv = cyc;
    if (m_valid === 1'b1 && rdy) begin
      if (pq.size() == 0) chk("spurious_valid", m_valid, 0);
      else begin
        e = pq.pop_front();
        chk("out_data", m_data, e.d);
        chk("out_tag", m_addr, e.a);
        chk("out_last", m_last, e.last);
        chk("out_frame", m_frame, e.f);
        if (e.last) mcount--;
      end
    end
    prev_mv = (m_valid === 1'b1); prev_rdy = rdy; prev_rd = (ram_read_en === 1'b1);
    prev_md = m_data; prev_ma = m_addr; prev_ml = m_last; prev_mf = m_frame;
    if (v) begin
      if (!mdrop) cur[idx] = '{d, a, 5'(wslot), idx == 7};
      if (idx == 7) begin
        if (!mdrop) begin
          for (int k = 0; k < 8; k++) pq.push_back(cur[k]);
          mcount++;
          wslot = (wslot + 1) % 30;
        end
        pix = 0;
      end else pix = idx + 1;
    end
    @(posedge clk); #1;
    chk("frames_stored", frames_stored, mcount);
    chk("overflow", overflow, exp_ov);
    chk("sof_err", sof_err, exp_se);
  endtask

  task automatic wr_frame(input logic [9:0] base, input logic rdy);
    for (int i = 0; i < 8; i++) cyc_step(1'b1, i == 0, base + 10'(i), 4'(i), rdy);
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while (mcount > 0 && n < max_cyc) begin
      cyc_step(1'b0, 1'b0, '0, '0, 1'b1);
      n++;
    end
    chk("drain_done", frames_stored, 0);
  endtask

  task automatic wait_valid(input logic rdy, input int max_cyc);
    int n = 0;
    while (m_valid !== 1'b1 && n < max_cyc) begin
      cyc_step(1'b0, 1'b0, '0, '0, rdy);
      n++;
    end
    chk("valid_timeout", m_valid, 1);
  endtask

  initial begin
    logic v, sof, rdy;
    int   n;
    model_clear();
    @(posedge clk); #1;
    do_reset();

    // Single frame, then read timing with m_ready held high
    wr_frame(10'h100, 1'b1);
    chk("one_frame", frames_stored, 1);
    drain(200);
    chk("rd_count", rd_cycles.size(), 8);
    for (int i = 1; i < rd_cycles.size(); i++)
      chk("rd_spacing", rd_cycles[i] - rd_cycles[i-1], 4);
    if (rd_cycles.size() > 0) chk("first_valid_lat", first_mv - rd_cycles[0], 3);

    // Ten-cycle stall while holding a pixel
    wr_frame(10'h2a0, 1'b0);
    wait_valid(1'b0, 20);
    for (int i = 0; i < 10; i++) cyc_step(1'b0, 1'b0, '0, '0, 1'b0);
    chk("stall_kept_valid", m_valid, 1);
    drain(200);

    // Mid-frame s_sof restart
    for (int i = 0; i < 3; i++) cyc_step(1'b1, i == 0, 10'h050 + 10'(i), 4'(i), 1'b0);
    wr_frame(10'h060, 1'b0);
    chk("restart_one_frame", frames_stored, 1);
    drain(200);

    // Commit coinciding with the final read handshake, then reset mid-read
    wr_frame(10'h300, 1'b0);
    for (int i = 0; i < 7; i++) cyc_step(1'b1, i == 0, 10'h310 + 10'(i), 4'(i), 1'b0);
    n = 0;
    while (!(m_valid === 1'b1 && m_last === 1'b1) && n < 200) begin
      cyc_step(1'b0, 1'b0, '0, '0, 1'b1);
      n++;
    end
    chk("last_timeout", m_last, 1);
    cyc_step(1'b1, 1'b0, 10'h317, 4'd7, 1'b1);
    chk("commit_pop_same", frames_stored, 1);
    wait_valid(1'b1, 20);
    cyc_step(1'b0, 1'b0, '0, '0, 1'b1);
    do_reset();

    // Fill the ring, overflow on the 31st frame, pop one, wrap to slot 0
    for (int f = 0; f < 30; f++) wr_frame(10'(f * 8), 1'b0);
    chk("full_count", frames_stored, 30);
    wr_frame(10'h3f0, 1'b0);
    chk("still_full", frames_stored, 30);
    n = 0;
    while (mcount > 29 && n < 100) begin
      cyc_step(1'b0, 1'b0, '0, '0, 1'b1);
      n++;
    end
    chk("pop_one", frames_stored, 29);
    cyc_step(1'b1, 1'b1, 10'h1ee, 4'hf, 1'b0);
    chk("wrap_slot", ram_frame_sel, 0);
    for (int i = 1; i < 8; i++) cyc_step(1'b1, 1'b0, 10'h1e0 + 10'(i), 4'(i), 1'b0);
    drain(2000);

    // Random traffic: write-heavy phase, then read-heavy phase
    for (int i = 0; i < 1600; i++) begin
      v   = ($urandom_range(9) < 7);
      sof = v && ((pix == 0) ? $urandom_range(1) == 1 : $urandom_range(39) == 0);
      rdy = (i < 800) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      cyc_step(v, sof, 10'($urandom), 4'($urandom), rdy);
    end
    drain(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
